control_seq: RTL and testbench

- Parametrised successor to the CPU control FSM; sequences fetch, register load, ALU, memory/port and pointer-update phases.
- Adds memory wait-state handshake (mem_ready) with a timeout, a HALT opcode with resume, and illegal-opcode detection.
- Sits between the instruction register/decoder and the datapath.
- Phase strobes are combinational decodes of the state register.

---
 rtl/control_seq.sv | 170 +++++++++++++++++
 tb/tb_control_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_seq.sv
// control_seq: instruction-phase sequencer for the CPU datapath.
// Ports: clk, rst_n, opcode, isaluop, mem_ready, resume (in);
//   do_fetch..do_next phase strobes, halted, illegal_op (pulse),
//   bus_err (sticky), state (debug) (out).
//   Optional CONTROL_STEP_EN adds step_en (single-step via HALT).
module control_seq #(
  parameter int unsigned OP_WIDTH = 4,
  parameter logic [OP_WIDTH-1:0] OP_NOP     = OP_WIDTH'(0),
  parameter logic [OP_WIDTH-1:0] OP_LOAD    = OP_WIDTH'(1),
  parameter logic [OP_WIDTH-1:0] OP_STORE   = OP_WIDTH'(2),
  parameter logic [OP_WIDTH-1:0] OP_LOADIMM = OP_WIDTH'(3),
  parameter logic [OP_WIDTH-1:0] OP_IN      = OP_WIDTH'(4),
  parameter logic [OP_WIDTH-1:0] OP_OUT     = OP_WIDTH'(5),
  parameter logic [OP_WIDTH-1:0] OP_JMP     = OP_WIDTH'(6),
  parameter logic [OP_WIDTH-1:0] OP_BR      = OP_WIDTH'(7),
  parameter logic [OP_WIDTH-1:0] OP_HALT    = OP_WIDTH'(8),
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_WIDTH-1:0] opcode,
  input  logic                isaluop,
  input  logic                mem_ready,
  input  logic                resume,
`ifdef CONTROL_STEP_EN
  input  logic                step_en,
`endif
  output logic                do_fetch,
  output logic                do_regload,
  output logic                do_aluop,
  output logic                do_regstore,
  output logic                do_load,
  output logic                do_store,
  output logic                do_next,
  output logic                halted,
  output logic                illegal_op,
  output logic                bus_err,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    REGLOAD  = 3'd1,
    ALUOP    = 3'd2,
    REGSTORE = 3'd3,
    LOAD     = 3'd4,
    STORE    = 3'd5,
    NEXT     = 3'd6,
    HALT     = 3'd7
  } state_t;

  // WAIT_MAX=0 would give a zero-width counter; keep one bit.
  localparam int CW =
    (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam bit TO_EN = (WAIT_MAX != 0);
  localparam logic [CW-1:0] WMAX = CW'(WAIT_MAX);

  state_t        st;
  state_t        rsm_tgt;
  logic [CW-1:0] cnt;

  logic dec_alu, dec_ld, dec_st, dec_imm;
  logic dec_br, dec_hlt, dec_ill;
  logic timeout;

  always_comb begin
    dec_alu = isaluop;
    dec_ld  = !isaluop &&
              (opcode == OP_LOAD || opcode == OP_IN);
    dec_st  = !isaluop &&
              (opcode == OP_STORE || opcode == OP_OUT);
    dec_imm = !isaluop && (opcode == OP_LOADIMM);
    dec_br  = !isaluop &&
              (opcode == OP_JMP || opcode == OP_BR);
    dec_hlt = !isaluop && (opcode == OP_HALT);
    dec_ill = !(dec_alu || dec_ld || dec_st ||
                dec_imm || dec_br || dec_hlt);
  end

  // Only meaningful in wait states with mem_ready low.
  assign timeout = TO_EN && (cnt == WMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= FETCH;
      rsm_tgt    <= NEXT;
      cnt        <= '0;
      illegal_op <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      // Counter only survives a stay in a wait state.
      cnt        <= '0;
      illegal_op <= 1'b0;
      unique case (st)
        FETCH: begin
          if (mem_ready) begin
            st <= (opcode == OP_NOP) ? NEXT : REGLOAD;
          end else if (timeout) begin
            st      <= HALT;
            rsm_tgt <= NEXT;
            bus_err <= 1'b1;
          end else if (TO_EN) begin
            cnt <= cnt + CW'(1);
          end
        end
        REGLOAD: begin
          unique case (1'b1)
            dec_alu: st <= ALUOP;
            dec_ld:  st <= LOAD;
            dec_st:  st <= STORE;
            dec_imm: st <= REGSTORE;
            dec_br:  st <= NEXT;
            dec_hlt: begin
              st      <= HALT;
              rsm_tgt <= NEXT;
            end
            dec_ill: begin
              st         <= NEXT;
              illegal_op <= 1'b1;
            end
          endcase
        end
        ALUOP:    st <= REGSTORE;
        REGSTORE: st <= NEXT;
        LOAD, STORE: begin
          if (mem_ready) begin
            st <= (st == LOAD) ? REGSTORE : NEXT;
          end else if (timeout) begin
            // Faulting instruction is skipped on resume.
            st      <= HALT;
            rsm_tgt <= NEXT;
            bus_err <= 1'b1;
          end else if (TO_EN) begin
            cnt <= cnt + CW'(1);
          end
        end
        NEXT: begin
`ifdef CONTROL_STEP_EN
          if (step_en) begin
            st      <= HALT;
            rsm_tgt <= FETCH;
          end else begin
            st <= FETCH;
          end
`else
          st <= FETCH;
`endif
        end
        HALT: begin
          if (resume) begin
            st      <= rsm_tgt;
            bus_err <= 1'b0;
          end
        end
        default: st <= FETCH;
      endcase
    end
  end

  assign do_fetch    = (st == FETCH);
  assign do_regload  = (st == REGLOAD);
  assign do_aluop    = (st == ALUOP);
  assign do_regstore = (st == REGSTORE);
  assign do_load     = (st == LOAD);
  assign do_store    = (st == STORE);
  assign do_next     = (st == NEXT);
  assign halted      = (st == HALT);
  assign state       = st;

endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: directed checks of control_seq phases,
// wait-state timeout, illegal opcode, halt/resume, step mode.
module tb_control_seq;

  logic       clk;
  logic       rst_n;
  logic [3:0] opcode;
  logic       isaluop;
  logic       mem_ready;
  logic       resume;
`ifdef CONTROL_STEP_EN
  logic       step_en;
`endif

  logic a_f, a_rl, a_al, a_rs, a_ld, a_st, a_nx;
  logic a_h, a_ill, a_be;
  logic [2:0] a_s;
  logic b_f, b_rl, b_al, b_rs, b_ld, b_st, b_nx;
  logic b_h, b_ill, b_be;
  logic [2:0] b_s;
  logic c_f, c_rl, c_al, c_rs, c_ld, c_st, c_nx;
  logic c_h, c_ill, c_be;
  logic [2:0] c_s;

  int checks = 0;
  int errors = 0;
  int npulse;

  control_seq #(.WAIT_MAX(15)) u15 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .isaluop(isaluop), .mem_ready(mem_ready),
    .resume(resume),
`ifdef CONTROL_STEP_EN
    .step_en(step_en),
`endif
    .do_fetch(a_f), .do_regload(a_rl), .do_aluop(a_al),
    .do_regstore(a_rs), .do_load(a_ld), .do_store(a_st),
    .do_next(a_nx), .halted(a_h), .illegal_op(a_ill),
    .bus_err(a_be), .state(a_s)
  );

  control_seq #(.WAIT_MAX(4)) u4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .isaluop(isaluop), .mem_ready(mem_ready),
    .resume(resume),
`ifdef CONTROL_STEP_EN
    .step_en(step_en),
`endif
    .do_fetch(b_f), .do_regload(b_rl), .do_aluop(b_al),
    .do_regstore(b_rs), .do_load(b_ld), .do_store(b_st),
    .do_next(b_nx), .halted(b_h), .illegal_op(b_ill),
    .bus_err(b_be), .state(b_s)
  );

  control_seq #(.WAIT_MAX(0)) u0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .isaluop(isaluop), .mem_ready(mem_ready),
    .resume(resume),
`ifdef CONTROL_STEP_EN
    .step_en(step_en),
`endif
    .do_fetch(c_f), .do_regload(c_rl), .do_aluop(c_al),
    .do_regstore(c_rs), .do_load(c_ld), .do_store(c_st),
    .do_next(c_nx), .halted(c_h), .illegal_op(c_ill),
    .bus_err(c_be), .state(c_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = 4'd0;
    isaluop   = 1'b0;
    mem_ready = 1'b0;
    resume    = 1'b0;
`ifdef CONTROL_STEP_EN
    step_en   = 1'b0;
`endif
    #12 rst_n = 1'b1;

    chk("rst_state", a_s, 8'd0);
    chk("rst_fetch", a_f, 8'd1);
    chk("rst_ill", a_ill, 8'd0);
    chk("rst_berr", a_be, 8'd0);

    // FETCH stalls while memory not ready
    tick(); chk("fetch_stall", a_s, 8'd0);

    // ALU op 0,1,2,3,6,0
    opcode = 4'd9; isaluop = 1'b1; mem_ready = 1'b1;
    tick(); chk("alu_s1", a_s, 8'd1);
    chk("alu_rl", a_rl, 8'd1);
    tick(); chk("alu_s2", a_s, 8'd2);
    chk("alu_al", a_al, 8'd1);
    tick(); chk("alu_s3", a_s, 8'd3);
    tick(); chk("alu_s6", a_s, 8'd6);
    chk("alu_nx", a_nx, 8'd1);
    tick(); chk("alu_s0", a_s, 8'd0);

    // NOP 0,6,0
    opcode = 4'd0; isaluop = 1'b0;
    tick(); chk("nop_s6", a_s, 8'd6);
    tick(); chk("nop_s0", a_s, 8'd0);

    // Async reset mid-ALUOP
    opcode = 4'd9; isaluop = 1'b1;
    tick(); tick(); chk("pre_rst_al", a_s, 8'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", a_s, 8'd0);
    chk("arst_fetch", a_f, 8'd1);
    chk("arst_alu", a_al, 8'd0);
    chk("arst_berr", a_be, 8'd0);
    chk("arst_ill", a_ill, 8'd0);
    #1 rst_n = 1'b1;

    // LOAD with 3 wait cycles
    opcode = 4'd1; isaluop = 1'b0; mem_ready = 1'b1;
    tick(); chk("ld_rl", a_s, 8'd1);
    mem_ready = 1'b0;
    tick(); chk("ld_w0", a_ld, 8'd1);
    tick(); chk("ld_w1", a_ld, 8'd1);
    tick(); chk("ld_w2", a_ld, 8'd1);
    tick(); chk("ld_w3", a_ld, 8'd1);
    mem_ready = 1'b1;
    tick(); chk("ld_rs", a_s, 8'd3);
    tick(); chk("ld_nx", a_s, 8'd6);
    chk("ld_berr", a_be, 8'd0);
    chk("ld_berr4", b_be, 8'd0);
    tick(); chk("ld_fetch", a_s, 8'd0);

    // STORE timeout on WAIT_MAX=4
    opcode = 4'd2;
    tick(); chk("to_rl", b_s, 8'd1);
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); chk("to_store", b_s, 8'd5);
    end
    tick();
    chk("to_halt", b_s, 8'd7);
    chk("to_halted", b_h, 8'd1);
    chk("to_berr", b_be, 8'd1);
    chk("to_w15", a_s, 8'd5);
    chk("to_w0", c_s, 8'd5);
    resume = 1'b1;
    tick();
    chk("to_rsm_nx", b_s, 8'd6);
    chk("to_rsm_berr", b_be, 8'd0);
    chk("ign_rsm", c_s, 8'd5);
    resume = 1'b0;
    tick(); chk("to_fetch", b_s, 8'd0);
    for (int i = 0; i < 20; i++) tick();
    chk("w0_unbound", c_s, 8'd5);
    chk("w0_berr", c_be, 8'd0);
    chk("w15_berr", a_be, 8'd1);
    do_reset();

    // Ready in the final wait cycle wins
    mem_ready = 1'b1;
    tick(); chk("rdy_rl", b_s, 8'd1);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); chk("rdy_store", b_s, 8'd5);
    end
    tick(); chk("rdy_last", b_s, 8'd5);
    mem_ready = 1'b1;
    tick();
    chk("rdy_nx", b_s, 8'd6);
    chk("rdy_berr", b_be, 8'd0);
    tick(); chk("rdy_fetch", b_s, 8'd0);

    // Illegal opcode
    opcode = 4'd12; isaluop = 1'b0;
    tick(); chk("ill_rl", a_s, 8'd1);
    chk("ill_lo", a_ill, 8'd0);
    tick(); chk("ill_nx", a_s, 8'd6);
    chk("ill_hi", a_ill, 8'd1);
    tick(); chk("ill_off", a_ill, 8'd0);
    chk("ill_fetch", a_s, 8'd0);

    // HALT opcode and resume
    opcode = 4'd8;
    tick(); chk("h_rl", a_s, 8'd1);
    tick(); chk("h_halt", a_h, 8'd1);
    for (int i = 0; i < 10; i++) begin
      tick(); chk("h_hold", a_s, 8'd7);
    end
    resume = 1'b1;
    tick(); chk("h_nx", a_s, 8'd6);
    resume = 1'b0;
    tick(); chk("h_fetch", a_s, 8'd0);

    // LOADIMM goes straight to REGSTORE
    opcode = 4'd3;
    tick(); chk("imm_rl", a_s, 8'd1);
    tick(); chk("imm_rs", a_s, 8'd3);
    tick(); chk("imm_nx", a_s, 8'd6);
    tick(); chk("imm_fetch", a_s, 8'd0);

`ifdef CONTROL_STEP_EN
    step_en = 1'b1;
    opcode = 4'd0;
    npulse = 0;
    for (int n = 0; n < 2; n++) begin
      tick(); chk("stp_nx", a_s, 8'd6);
      if (a_nx) npulse++;
      tick(); chk("stp_halt", a_s, 8'd7);
      tick(); chk("stp_hold", a_s, 8'd7);
      resume = 1'b1;
      tick(); chk("stp_fetch", a_s, 8'd0);
      resume = 1'b0;
    end
    chk("stp_pulses", 8'(npulse), 8'd2);
    step_en = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
